// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the two-port ROM burst arbiter: FSM encoding,
// port indices and burst-length width.
package rom_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int LEN_W = 2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// port that did not win last time.
module rr_pick2
    import rom_port_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = {req1, req0};
        if (req0 && req1) begin
            gnt = (last == PORT_IF) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates two burst readers onto one combinational ROM; read data comes
// back registered, one word per cycle, two cycles after the grant.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic             rlast,
    output logic [DW-1:0]    rdata,
    output logic [AW-1:0]    rom_addr,
    output logic             rom_sel,
    input  logic [DW-1:0]    rom_data
);

    state_t           state_reg, state_next;
    logic             last_reg, last_next;
    logic [AW-1:0]    addr_reg, addr_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             rvalid0_reg, rvalid1_reg, rlast_reg;
    logic [DW-1:0]    rdata_reg;
    logic [1:0]       pick;
    logic             in_burst;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_reg),
        .gnt  (pick)
    );

    assign in_burst = (state_reg == ST_BURST);

    // Grants are combinational so the burst owner is latched on the same edge;
    // gating with rst_n keeps them low while reset is held.
    assign gnt0 = rst_n && !in_burst && pick[0];
    assign gnt1 = rst_n && !in_burst && pick[1];

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    state_next = ST_BURST;
                    last_next  = gnt1 ? PORT_DBG : PORT_IF;
                    addr_next  = gnt1 ? addr1 : addr0;
                    cnt_next   = gnt1 ? len1 : len0;
                end
            end
            ST_BURST: begin
                // The address stops on the final word so IDLE shows the last one read.
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next  = cnt_reg - LEN_W'(1);
                    addr_next = addr_reg + AW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            last_reg    <= PORT_DBG;
            addr_reg    <= '0;
            cnt_reg     <= '0;
            rvalid0_reg <= 1'b0;
            rvalid1_reg <= 1'b0;
            rlast_reg   <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            addr_reg    <= addr_next;
            cnt_reg     <= cnt_next;
            rvalid0_reg <= in_burst && (last_reg == PORT_IF);
            rvalid1_reg <= in_burst && (last_reg == PORT_DBG);
            rlast_reg   <= in_burst && (cnt_reg == '0);
            if (in_burst) begin
                rdata_reg <= rom_data;
            end
        end
    end

    assign rom_sel  = in_burst;
    assign rom_addr = addr_reg;
    assign rvalid0  = rvalid0_reg;
    assign rvalid1  = rvalid1_reg;
    assign rlast    = rlast_reg;
    assign rdata    = rdata_reg;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against a burst-schedule model.
module tb_rom_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [1:0]    len0 = '0, len1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, rlast, rom_sel;
    logic [DW-1:0] rdata, rom_data;
    logic [AW-1:0] rom_addr;

    always #5 clk = ~clk;

    // ROM contents: C0DE in the top half, the word address in the low bits.
    assign rom_data = {16'hC0DE, 6'd0, rom_addr};

    rom_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .len0     (len0),
        .len1     (len1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rlast    (rlast),
        .rdata    (rdata),
        .rom_addr (rom_addr),
        .rom_sel  (rom_sel),
        .rom_data (rom_data)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: each grant schedules its future ROM-read and read-data cycles.
    bit          r_sel [16];
    int          r_addr[16];
    bit          r_rv0 [16];
    bit          r_rv1 [16];
    bit          r_last[16];
    logic [31:0] r_data[16];
    int          free_at = 0;
    int          last_port = 1;
    int          m_addr = 0;
    logic [31:0] m_rdata = '0;
    bit          e_g0, e_g1;

    bit pend0 = 0, pend1 = 0;
    int pa0 = 0, pa1 = 0, pl0 = 0, pl1 = 0;
    bit rst_cmd = 0;

    function automatic logic [31:0] rom_fn(input int a);
        logic [AW-1:0] aa;
        aa = AW'(a);
        return {16'hC0DE, 6'd0, aa};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_slot(input int s);
        r_sel[s] = 0; r_addr[s] = 0; r_rv0[s] = 0; r_rv1[s] = 0; r_last[s] = 0; r_data[s] = '0;
    endtask

    task automatic model_cycle();
        int s;
        s = cyc & 15;
        e_g0 = 0;
        e_g1 = 0;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) clear_slot(i);
            free_at = 0;
            last_port = 1;
            m_addr = 0;
            m_rdata = '0;
        end else begin
            if (cyc >= free_at) begin
                int p;
                p = -1;
                if (req0 && req1) p = 1 - last_port;
                else if (req0)    p = 0;
                else if (req1)    p = 1;
                if (p >= 0) begin
                    int a, l;
                    a = (p == 0) ? int'(addr0) : int'(addr1);
                    l = (p == 0) ? int'(len0) : int'(len1);
                    last_port = p;
                    if (p == 0) e_g0 = 1; else e_g1 = 1;
                    for (int k = 0; k <= l; k++) begin
                        int t1, t2;
                        t1 = (cyc + 1 + k) & 15;
                        t2 = (cyc + 2 + k) & 15;
                        r_sel[t1]  = 1;
                        r_addr[t1] = (a + k) & ((1 << AW) - 1);
                        if (p == 0) r_rv0[t2] = 1; else r_rv1[t2] = 1;
                        r_data[t2] = rom_fn(a + k);
                        r_last[t2] = (k == l);
                    end
                    free_at = cyc + l + 2;
                end
            end
            if (r_sel[s]) m_addr = r_addr[s];
            if (r_rv0[s] || r_rv1[s]) m_rdata = r_data[s];
        end
        chk("gnt0", gnt0, e_g0);
        chk("gnt1", gnt1, e_g1);
        chk("rvalid0", rvalid0, r_rv0[s]);
        chk("rvalid1", rvalid1, r_rv1[s]);
        chk("rlast", rlast, r_last[s]);
        chk("rom_sel", rom_sel, r_sel[s]);
        chk("rom_addr", rom_addr, m_addr);
        chk("one_rvalid", rvalid0 & rvalid1, 0);
        if (!rst_n || r_rv0[s] || r_rv1[s]) chk("rdata", rdata, m_rdata);
        clear_slot(s);
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        rst_n = rst_cmd;
        req0  = pend0;
        req1  = pend1;
        addr0 = AW'(pa0);
        addr1 = AW'(pa1);
        len0  = 2'(pl0);
        len1  = 2'(pl1);
        #1;
        model_cycle();
        if (e_g0) pend0 = 0;
        if (e_g1) pend1 = 0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int rv_cnt, gstart, found;
        logic [AW-1:0] wseq[4];
        int gq[$];
        wseq = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

        // Reset state
        rst_cmd = 0;
        step();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rom_sel", rom_sel, 0);
        step();
        rst_cmd = 1;
        idle_steps(2);

        // Single read
        pend0 = 1; pa0 = 'h010; pl0 = 0;
        step(); chk("single_gnt0", gnt0, 1);
        step(); chk("single_addr", rom_addr, 'h010); chk("single_sel", rom_sel, 1);
        step(); chk("single_rv0", rvalid0, 1); chk("single_rlast", rlast, 1);
        chk("single_rdata", rdata, 32'hC0DE0010);
        idle_steps(2);

        // Burst wrapping past the top of the address space
        pend1 = 1; pa1 = 'h3FE; pl1 = 3;
        step(); chk("wrap_gnt1", gnt1, 1);
        rv_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i <= 4) chk("wrap_addr", rom_addr, wseq[i-1]);
            if (i >= 2) rv_cnt += int'(rvalid1);
            if (i == 5) chk("wrap_rlast", rlast, 1);
        end
        chk("wrap_rv_count", rv_cnt, 4);
        idle_steps(2);

        // Contention from reset
        rst_cmd = 0; step(); step();
        pend0 = 1; pa0 = 'h040; pl0 = 1;
        pend1 = 1; pa1 = 'h080; pl1 = 1;
        rst_cmd = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (gnt0) gq.push_back(0);
            if (gnt1) gq.push_back(1);
            pend0 = 1; pend1 = 1;
        end
        chk("cont_ngrants", (gq.size() >= 4) ? 1 : 0, 1);
        if (gq.size() >= 4) begin
            chk("cont_g0", gq[0], 0); chk("cont_g1", gq[1], 1);
            chk("cont_g2", gq[2], 0); chk("cont_g3", gq[3], 1);
        end
        pend0 = 0; pend1 = 0;
        idle_steps(6);

        // Back-to-back single-word bursts on port 0
        pend0 = 1; pa0 = 5; pl0 = 0;
        step(); chk("b2b_gnt_a", gnt0, 1);
        pend0 = 1; pa0 = 6;
        step(); chk("b2b_wait", gnt0, 0);
        step(); chk("b2b_gnt_b", gnt0, 1); chk("b2b_rv0", rvalid0, 1);
        idle_steps(4);

        // Reset in the middle of a four-word burst
        pend0 = 1; pa0 = 'h100; pl0 = 3;
        step(); chk("mid_gnt0", gnt0, 1);
        step(); step();
        rst_cmd = 0;
        step();
        chk("mid_rv0", rvalid0, 0); chk("mid_sel", rom_sel, 0);
        chk("mid_addr", rom_addr, 0); chk("mid_rdata", rdata, 0); chk("mid_rlast", rlast, 0);
        pend0 = 1; pa0 = 'h200; pl0 = 0;
        pend1 = 1; pa1 = 'h300; pl1 = 0;
        step(); chk("mid_no_gnt", gnt0 | gnt1, 0);
        rst_cmd = 1;
        step(); chk("mid_after_gnt0", gnt0, 1); chk("mid_after_gnt1", gnt1, 0);
        idle_steps(8);

        // Request arriving during another port's burst
        pend0 = 1; pa0 = 'h020; pl0 = 3;
        step(); chk("late_gnt0", gnt0, 1);
        gstart = cyc - 1;
        step();
        pend1 = 1; pa1 = 'h030; pl1 = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (gnt1) begin
                found = 1;
                chk("late_gnt1_delay", (cyc - 1) - gstart, 5);
            end
        end
        if (!found) chk("late_gnt1_timeout", 0, 1);
        idle_steps(4);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1; pa0 = int'($urandom_range(0, 1023)); pl0 = int'($urandom_range(0, 3));
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1; pa1 = int'($urandom_range(0, 1023)); pl1 = int'($urandom_range(0, 3));
            end
            rst_cmd = ($urandom_range(0, 149) != 0);
            step();
        end
        rst_cmd = 1; pend0 = 0; pend1 = 0;
        idle_steps(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning ROM word-address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning ROM data width.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0 / req1  input  1 each  request from port 0 (instruction fetch) or port 1 (data/debug reader); held high until granted.
REQ-006 addr0 / addr1  input  AW each  start word address; held stable while req high.
REQ-007 len0 / len1  input  2 each  burst length minus one (0..3 means 1..4 words); held stable while req high.
REQ-008 gnt0 / gnt1  output  1 each  one-cycle pulse when that port's request is accepted.
REQ-009 rvalid0 / rvalid1  output  1 each  high for the cycle in which rdata carries one word for that port.
REQ-010 rlast  output  1  high with the final rvalid of a burst.
REQ-011 rdata  output  DW  registered read data, shared by both ports.
REQ-012 rom_addr  output  AW  address to the ROM.
REQ-013 rom_sel  output  1  ROM select; high only when a word is being read.
REQ-014 rom_data  input  DW  combinational ROM output for rom_addr.

Function
REQ-015 States SHALL be IDLE and BURST.
REQ-016 In IDLE with exactly one req high, that port SHALL be granted: gntN pulses, the address, length and owner are latched, and the state moves to BURST on the same edge.
REQ-017 In IDLE with both req high, the grant SHALL go to the port not granted last (round-robin), and to port 0 after reset.
REQ-018 In BURST, rom_sel SHALL be 1 and rom_addr SHALL equal the current latched address every cycle; the address SHALL increment by 1 per cycle and wrap from 2**AW-1 to 0.
REQ-019 Each BURST cycle's rom_data SHALL be registered into rdata, with rvalidN asserted for the owning port on the next cycle; latency from grant to first rvalid is 2 cycles.
REQ-020 A remaining-word counter SHALL load lenN on grant and decrement each BURST cycle; when it reaches 0 the state SHALL return to IDLE; rlast SHALL be high with the corresponding final rvalid.
REQ-021 A new grant SHALL be possible in the IDLE cycle immediately after a burst ends; rvalid/rlast of the old burst SHALL still be delivered in that cycle, and at most one rvalid SHALL be high in any cycle.
REQ-022 Requests arriving during BURST SHALL wait; they SHALL NOT be granted or dropped.
REQ-023 In IDLE, rom_sel SHALL be 0 and rom_addr SHALL hold its last value.
REQ-024 No backpressure: a requester SHALL accept each rvalid word in the cycle it is presented.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state IDLE, with gnt*, rvalid*, rlast, rom_sel = 0, rom_addr = 0, rdata = 0, counter = 0, and last-grant pointer set so that port 0 wins next.
REQ-026 A burst interrupted by reset SHALL be abandoned with no further rvalid; after deassertion the requester SHALL re-request.

Structure
REQ-027 The state encoding, the port-index constants (PORT_IF = 0, PORT_DBG = 1), and the burst-length width SHALL reside in the shared CPU package.
REQ-028 The round-robin selector SHALL be a sub-module named rr_pick2 (inputs: two requests and the last-grant bit; output: grant one-hot).
REQ-029 The ROM itself SHALL stay outside this block and be connected through the rom_* ports.

Verification
REQ-030 Single read: req0=1, addr0=0x010, len0=0 -> gnt0 pulses at cycle 0; rom_addr=0x010 at cycle 1; rvalid0=1, rlast=1, rdata=ROM[0x010] at cycle 2.
REQ-031 Burst wrap: req1, addr1=0x3FE, len1=3 -> rom_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; four rvalid1; rlast on the 4th.
REQ-032 Contention: req0 and req1 held high from reset, len=1 each -> grants in the order 0, 1, 0, 1; no cycle with both rvalid high.
REQ-033 Back-to-back: req0 held for two 1-word bursts -> second gnt0 in the IDLE cycle after the first burst ends, while rvalid0 of the first burst is high.
REQ-034 Reset mid-burst: rst_n low during the 2nd word of a 4-word burst -> all outputs 0 at once; no further rvalid; the next grant after reset goes to port 0.
REQ-035 Late request: req1 rises during a port-0 burst -> gnt1 only after the burst ends, and req1 is never lost.
